// File: rtl/pc_predictor.sv
// Fetch-stage next-PC generator with a saturating-counter pattern-history table,
// bimodal or gshare indexed, JAL redirect, misbranch recovery and commit-time training.
module pc_predictor #(
    parameter int unsigned IDX_BITS  = 6,
    parameter int unsigned CNT_BITS  = 2,
    parameter int unsigned HIST_BITS = 6,
    parameter int unsigned MODE      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [31:0]          in_last_pc,
    input  logic [31:0]          in_last_inst,
    output logic [31:0]          out_next_pc,
    output logic                 out_pred_taken,
    output logic [HIST_BITS-1:0] out_pred_hist,
    input  logic                 in_upd_valid,
    input  logic [31:0]          in_upd_pc,
    input  logic [HIST_BITS-1:0] in_upd_hist,
    input  logic                 in_upd_taken,
    input  logic                 in_misbranch,
    input  logic [31:0]          in_correct_addr,
    output logic                 out_clear_all
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0]          next_pc_q, next_pc_d;
    logic                 pred_taken_q, pred_taken_d;
    logic [HIST_BITS-1:0] pred_hist_q, pred_hist_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [CNT_BITS-1:0]  pht_q [ENTRIES];
    logic [CNT_BITS-1:0]  pht_d [ENTRIES];

    logic [IDX_BITS-1:0]  pred_idx;
    logic [IDX_BITS-1:0]  upd_idx;
    logic [CNT_BITS-1:0]  upd_cnt;
    logic                 pred_t;
    logic [6:0]           opcode;
    logic [31:0]          b_imm;
    logic [31:0]          j_imm;
    logic                 unused_upd_pc_bits;

    function automatic logic [IDX_BITS-1:0] pht_index(input logic [31:0] pc,
                                                      input logic [HIST_BITS-1:0] hist);
        logic [IDX_BITS-1:0] idx;
        idx = pc[IDX_BITS+1:2];
        if (MODE != 0) begin
            idx = idx ^ IDX_BITS'(hist);
        end
        return idx;
    endfunction

    // Widened concatenation keeps the shift legal for a 1-bit history.
    function automatic logic [HIST_BITS-1:0] hist_push(input logic [HIST_BITS-1:0] h,
                                                       input logic b);
        logic [HIST_BITS:0] w;
        w = {h, b};
        return w[HIST_BITS-1:0];
    endfunction

    assign opcode = in_last_inst[6:0];
    assign b_imm  = {{19{in_last_inst[31]}}, in_last_inst[31], in_last_inst[7],
                     in_last_inst[30:25], in_last_inst[11:8], 1'b0};
    assign j_imm  = {{11{in_last_inst[31]}}, in_last_inst[31], in_last_inst[19:12],
                     in_last_inst[20], in_last_inst[30:21], 1'b0};

    assign unused_upd_pc_bits = ^{in_upd_pc[31:IDX_BITS+2], in_upd_pc[1:0]};

    always_comb begin
        next_pc_d    = next_pc_q;
        pred_taken_d = pred_taken_q;
        pred_hist_d  = pred_hist_q;
        ghr_d        = ghr_q;
        pred_idx     = pht_index(in_last_pc, ghr_q);
        pred_t       = pht_q[pred_idx][CNT_BITS-1];
        if (ena) begin
            if (in_misbranch) begin
                next_pc_d    = in_correct_addr;
                pred_taken_d = 1'b0;
                ghr_d        = hist_push(in_upd_hist, in_upd_taken);
            end else if (opcode == OP_BRANCH) begin
                next_pc_d    = pred_t ? (in_last_pc + b_imm) : (in_last_pc + 32'd4);
                pred_taken_d = pred_t;
                pred_hist_d  = ghr_q;
                ghr_d        = hist_push(ghr_q, pred_t);
            end else if (opcode == OP_JAL) begin
                next_pc_d    = in_last_pc + j_imm;
                pred_taken_d = 1'b0;
            end else begin
                next_pc_d    = in_last_pc + 32'd4;
                pred_taken_d = 1'b0;
            end
        end
    end

    // Training reads pht_q, so a same-cycle prediction sees the pre-update counter.
    always_comb begin
        pht_d   = pht_q;
        upd_idx = pht_index(in_upd_pc, in_upd_hist);
        upd_cnt = pht_q[upd_idx];
        if (in_upd_valid) begin
            if (in_upd_taken) begin
                if (upd_cnt != CNT_MAX) begin
                    pht_d[upd_idx] = upd_cnt + 1'b1;
                end
            end else if (upd_cnt != '0) begin
                pht_d[upd_idx] = upd_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_pc_q    <= '0;
            pred_taken_q <= 1'b0;
            pred_hist_q  <= '0;
            ghr_q        <= '0;
            pht_q        <= '{default: CNT_INIT};
        end else begin
            next_pc_q    <= next_pc_d;
            pred_taken_q <= pred_taken_d;
            pred_hist_q  <= pred_hist_d;
            ghr_q        <= ghr_d;
            pht_q        <= pht_d;
        end
    end

    assign out_next_pc    = next_pc_q;
    assign out_pred_taken = pred_taken_q;
    assign out_pred_hist  = pred_hist_q;
    assign out_clear_all  = in_misbranch;

endmodule

// File: tb/tb_pc_predictor.sv
// Directed bench for pc_predictor: a gshare and a bimodal instance share one stimulus stream.
module tb_pc_predictor;

    localparam logic [31:0] NOP     = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] BR_M8   = 32'hFE000CE3; // beq x0,x0,-8
    localparam logic [31:0] BNE_P16 = 32'h00001863; // bne x0,x0,+16
    localparam logic [31:0] JAL_800 = 32'h0010006F; // jal x0,+0x800
    localparam logic [31:0] JAL_M4  = 32'hFFDFF06F; // jal x0,-4
    localparam logic [31:0] JALR    = 32'h00008067; // jalr x0,0(x1)

    logic        clk;
    logic        rst;
    logic        ena;
    logic [31:0] in_last_pc;
    logic [31:0] in_last_inst;
    logic        in_upd_valid;
    logic [31:0] in_upd_pc;
    logic [5:0]  in_upd_hist;
    logic        in_upd_taken;
    logic        in_misbranch;
    logic [31:0] in_correct_addr;

    logic [31:0] g_next_pc, b_next_pc;
    logic        g_taken, b_taken;
    logic [5:0]  g_hist, b_hist;
    logic        g_clear, b_clear;

    int n_checks = 0;
    int n_fail   = 0;

    pc_predictor #(.IDX_BITS(6), .CNT_BITS(2), .HIST_BITS(6), .MODE(1)) dut_g (
        .clk(clk), .rst(rst), .ena(ena),
        .in_last_pc(in_last_pc), .in_last_inst(in_last_inst),
        .out_next_pc(g_next_pc), .out_pred_taken(g_taken), .out_pred_hist(g_hist),
        .in_upd_valid(in_upd_valid), .in_upd_pc(in_upd_pc), .in_upd_hist(in_upd_hist),
        .in_upd_taken(in_upd_taken), .in_misbranch(in_misbranch),
        .in_correct_addr(in_correct_addr), .out_clear_all(g_clear)
    );

    pc_predictor #(.IDX_BITS(6), .CNT_BITS(2), .HIST_BITS(6), .MODE(0)) dut_b (
        .clk(clk), .rst(rst), .ena(ena),
        .in_last_pc(in_last_pc), .in_last_inst(in_last_inst),
        .out_next_pc(b_next_pc), .out_pred_taken(b_taken), .out_pred_hist(b_hist),
        .in_upd_valid(in_upd_valid), .in_upd_pc(in_upd_pc), .in_upd_hist(in_upd_hist),
        .in_upd_taken(in_upd_taken), .in_misbranch(in_misbranch),
        .in_correct_addr(in_correct_addr), .out_clear_all(b_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exp_pc;
        logic        exp_taken;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        in_last_pc   = pc;
        in_last_inst = inst;
        tick();
    endtask

    task automatic train(input logic [31:0] pc, input logic [5:0] hist, input logic taken);
        in_upd_valid = 1'b1;
        in_upd_pc    = pc;
        in_upd_hist  = hist;
        in_upd_taken = taken;
        fetch(32'h100, NOP);
        in_upd_valid = 1'b0;
    endtask

    task automatic bpred(input string name, input logic [31:0] pc, input logic [31:0] exp_pc,
                         input logic exp_t);
        fetch(pc, BR_M8);
        chk({name, "_pc"}, b_next_pc, exp_pc);
        chk({name, "_tk"}, {31'd0, b_taken}, {31'd0, exp_t});
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_g_pc"}, g_next_pc, 32'h0);
        chk({name, "_g_tk"}, {31'd0, g_taken}, 32'h0);
        chk({name, "_g_hist"}, {26'd0, g_hist}, 32'h0);
        chk({name, "_b_pc"}, b_next_pc, 32'h0);
        chk({name, "_b_tk"}, {31'd0, b_taken}, 32'h0);
        chk({name, "_b_hist"}, {26'd0, b_hist}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{"addi",      32'h0000_0100, NOP,     32'h0000_0104, 1'b0};
        vecs[1] = '{"beq_nt",    32'h0000_0200, BR_M8,   32'h0000_0204, 1'b0};
        vecs[2] = '{"jal_wrap",  32'hFFFF_F900, JAL_800, 32'h0000_0100, 1'b0};
        vecs[3] = '{"pc4_wrap",  32'hFFFF_FFFC, NOP,     32'h0000_0000, 1'b0};
        vecs[4] = '{"jal_neg",   32'h0000_1000, JAL_M4,  32'h0000_0FFC, 1'b0};
        vecs[5] = '{"bne_nt",    32'h0000_0300, BNE_P16, 32'h0000_0304, 1'b0};
        vecs[6] = '{"jalr_seq",  32'h0000_0400, JALR,    32'h0000_0404, 1'b0};

        rst = 1'b1; ena = 1'b1;
        in_last_pc = 32'h100; in_last_inst = NOP;
        in_upd_valid = 1'b0; in_upd_pc = '0; in_upd_hist = '0; in_upd_taken = 1'b0;
        in_misbranch = 1'b0; in_correct_addr = '0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        // All counters weakly not-taken: both indexings agree on every vector.
        for (int i = 0; i < 7; i++) begin
            fetch(vecs[i].pc, vecs[i].inst);
            chk({vecs[i].name, "_g_pc"}, g_next_pc, vecs[i].exp_pc);
            chk({vecs[i].name, "_g_tk"}, {31'd0, g_taken}, {31'd0, vecs[i].exp_taken});
            chk({vecs[i].name, "_b_pc"}, b_next_pc, vecs[i].exp_pc);
            chk({vecs[i].name, "_b_tk"}, {31'd0, b_taken}, {31'd0, vecs[i].exp_taken});
        end

        // Bimodal training on entry 0 (pc 0x200); same-cycle update is not visible.
        in_upd_valid = 1'b1; in_upd_pc = 32'h200; in_upd_hist = '0; in_upd_taken = 1'b1;
        fetch(32'h200, BR_M8);
        in_upd_valid = 1'b0;
        chk("rbw_pc", b_next_pc, 32'h204);
        chk("rbw_tk", {31'd0, b_taken}, 32'h0);
        bpred("cnt2", 32'h200, 32'h1F8, 1'b1);
        train(32'h200, 6'd0, 1'b1);
        bpred("cnt3", 32'h200, 32'h1F8, 1'b1);
        train(32'h200, 6'd0, 1'b1);
        train(32'h200, 6'd0, 1'b0);
        bpred("sat_hi", 32'h200, 32'h1F8, 1'b1);
        train(32'h200, 6'd0, 1'b0);
        bpred("dec1", 32'h200, 32'h204, 1'b0);
        train(32'h200, 6'd0, 1'b0);
        train(32'h200, 6'd0, 1'b0);
        train(32'h200, 6'd0, 1'b1);
        bpred("sat_lo", 32'h200, 32'h204, 1'b0);
        train(32'h200, 6'd0, 1'b1);
        bpred("inc2", 32'h200, 32'h1F8, 1'b1);

        // Stall: outputs frozen, training continues, misbranch waits for ena.
        ena = 1'b0;
        in_last_pc = 32'h1000; in_last_inst = JAL_M4;
        for (int k = 0; k < 3; k++) begin
            in_upd_valid = 1'b1; in_upd_pc = 32'h200; in_upd_hist = '0; in_upd_taken = 1'b0;
            if (k == 2) begin
                in_misbranch = 1'b1;
                in_correct_addr = 32'h500;
            end
            #1;
            chk("stall_clear", {31'd0, b_clear}, (k == 2) ? 32'h1 : 32'h0);
            tick();
            chk("stall_pc", b_next_pc, 32'h1F8);
            chk("stall_tk", {31'd0, b_taken}, 32'h1);
        end
        ena = 1'b1;
        tick();
        chk("redirect_b_pc", b_next_pc, 32'h500);
        chk("redirect_b_tk", {31'd0, b_taken}, 32'h0);
        chk("redirect_g_pc", g_next_pc, 32'h500);
        in_misbranch = 1'b0; in_upd_valid = 1'b0;
        #1;
        chk("clear_low", {31'd0, b_clear}, 32'h0);
        bpred("stall_trained", 32'h200, 32'h204, 1'b0);

        // Reset during a stall discards the pending redirect and the update.
        ena = 1'b0;
        in_upd_valid = 1'b1; in_upd_pc = 32'h104; in_upd_hist = '0; in_upd_taken = 1'b1;
        tick();
        rst = 1'b1; in_misbranch = 1'b1; in_correct_addr = 32'h500;
        tick();
        chk_reset("rst_stall");
        rst = 1'b0; in_misbranch = 1'b0; in_upd_valid = 1'b0; ena = 1'b1;
        bpred("rst_cnt", 32'h104, 32'h108, 1'b0);
        chk("rst_cnt_g_pc", g_next_pc, 32'h108);

        // Gshare: misbranch restores history, JAL leaves it, index folds history in.
        in_last_pc = 32'h100; in_last_inst = NOP;
        in_misbranch = 1'b1; in_correct_addr = 32'h300;
        in_upd_valid = 1'b1; in_upd_pc = 32'h200; in_upd_hist = 6'b000001; in_upd_taken = 1'b1;
        #1;
        chk("clear_comb", {31'd0, g_clear}, 32'h1);
        tick();
        chk("mis_g_pc", g_next_pc, 32'h300);
        chk("mis_g_tk", {31'd0, g_taken}, 32'h0);
        in_misbranch = 1'b0; in_upd_valid = 1'b0;
        fetch(32'hFFFF_F900, JAL_800);
        chk("jal_g_pc", g_next_pc, 32'h100);
        fetch(32'h200, BR_M8);
        chk("ghr_mis_pc", g_next_pc, 32'h204);
        chk("ghr_mis_hist", {26'd0, g_hist}, {26'd0, 6'b000011});

        in_misbranch = 1'b1; in_correct_addr = 32'h40;
        in_upd_valid = 1'b1; in_upd_pc = 32'h200; in_upd_hist = 6'b000010; in_upd_taken = 1'b1;
        tick();
        chk("mis2_g_pc", g_next_pc, 32'h40);
        in_misbranch = 1'b0; in_upd_valid = 1'b0;
        train(32'h40, 6'b000101, 1'b1);
        train(32'h40, 6'b000101, 1'b1);
        fetch(32'h40, BR_M8);
        chk("gs21_pc", g_next_pc, 32'h38);
        chk("gs21_tk", {31'd0, g_taken}, 32'h1);
        chk("gs21_hist", {26'd0, g_hist}, {26'd0, 6'b000101});
        fetch(32'h40, BR_M8);
        chk("gs27_pc", g_next_pc, 32'h44);
        chk("gs27_tk", {31'd0, g_taken}, 32'h0);
        chk("gs27_hist", {26'd0, g_hist}, {26'd0, 6'b001011});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
